ay_dac_mixer: RTL and testbench

//  Parametrised AY-3-8913-style volume mixer feeding the analog DAC.
//  - Holds a 4-bit logarithmic volume register per channel.
//  - Once per sample period, converts each gated channel volume to linear amplitude

---
 rtl/ay_dac_mixer.sv | 127 ++++++++++++
 tb/tb_ay_dac_mixer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ay_dac_mixer.sv
// rtl/ay_dac_mixer.sv - AY-style log-volume mixer producing a linear DAC code per sample period.
// Optional first-order sigma-delta bitstream on pdm_out when SIGMA_DELTA_EN is defined.
module ay_dac_mixer #(
    parameter int CHANNELS   = 3,
    parameter int SAMPLE_DIV = 32,
    parameter int LIN_W      = 8,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int SUM_W     = LIN_W + $clog2(CHANNELS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [3:0]          wr_vol,
    input  logic [CHANNELS-1:0] ch_on,
    output logic [SUM_W-1:0]    dac_code,
    output logic                sample_valid,
    output logic                pdm_out
);

    localparam int PH_W = $clog2(SAMPLE_DIV);

    generate
        if (CHANNELS < 1 || CHANNELS > 8 || SAMPLE_DIV < CHANNELS + 2) begin : g_bad_cfg
            $error("ay_dac_mixer: CHANNELS must be 1..8 and SAMPLE_DIV >= CHANNELS+2");
        end
    endgenerate

    // AY 3 dB/step curve, rescaled with rounding when LIN_W differs from 8.
    function automatic logic [LIN_W-1:0] lut(input logic [3:0] v);
        longint t;
        t = 0;
        case (v)
            4'd0:  t = 0;
            4'd1:  t = 2;
            4'd2:  t = 3;
            4'd3:  t = 4;
            4'd4:  t = 6;
            4'd5:  t = 8;
            4'd6:  t = 11;
            4'd7:  t = 16;
            4'd8:  t = 23;
            4'd9:  t = 32;
            4'd10: t = 45;
            4'd11: t = 64;
            4'd12: t = 90;
            4'd13: t = 128;
            4'd14: t = 181;
            default: t = 255;
        endcase
        return LIN_W'((t * ((longint'(1) << LIN_W) - 1) + 127) / 255);
    endfunction

    logic [3:0]          r_vol      [CHANNELS];
    logic [3:0]          r_snap_vol [CHANNELS];
    logic [CHANNELS-1:0] r_snap_on;
    logic [PH_W-1:0]     r_phase;
    logic [SUM_W-1:0]    r_acc;
    logic [SUM_W-1:0]    r_dac;
    logic                r_valid;
    logic [LIN_W-1:0]    w_add;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) r_vol[k] <= 4'd0;
        end else begin
            // Out-of-range channel indices match no k and are silently dropped.
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_en && wr_ch == CH_W'(k)) r_vol[k] <= wr_vol;
            end
        end
    end

    always_comb begin
        w_add = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (r_phase == PH_W'(k + 1) && r_snap_on[k]) w_add = lut(r_snap_vol[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= '0;
            r_acc     <= '0;
            r_dac     <= '0;
            r_valid   <= 1'b0;
            r_snap_on <= '0;
            for (int k = 0; k < CHANNELS; k++) r_snap_vol[k] <= 4'd0;
        end else begin
            r_phase <= (r_phase == PH_W'(SAMPLE_DIV - 1)) ? '0 : r_phase + 1'b1;
            r_valid <= 1'b0;
            if (r_phase == '0) begin
                r_acc     <= '0;
                r_snap_on <= ch_on;
                for (int k = 0; k < CHANNELS; k++) r_snap_vol[k] <= r_vol[k];
            end else if (r_phase <= PH_W'(CHANNELS)) begin
                r_acc <= r_acc + SUM_W'(w_add);
            end else if (r_phase == PH_W'(CHANNELS + 1)) begin
                r_dac   <= r_acc;
                r_valid <= 1'b1;
            end
        end
    end

    assign dac_code     = r_dac;
    assign sample_valid = r_valid;

`ifdef SIGMA_DELTA_EN
    logic [SUM_W:0] r_integ;
    logic           r_pdm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_integ <= '0;
            r_pdm   <= 1'b0;
        end else begin
            r_integ <= {1'b0, r_integ[SUM_W-1:0]} + (SUM_W + 1)'(r_dac);
            r_pdm   <= r_integ[SUM_W];
        end
    end

    assign pdm_out = r_pdm;
`else
    assign pdm_out = 1'b0;
`endif

endmodule

// File: tb/tb_ay_dac_mixer.sv
// tb/tb_ay_dac_mixer.sv - self-checking bench for ay_dac_mixer (CHANNELS=3, SAMPLE_DIV=32, LIN_W=8).
module tb_ay_dac_mixer;

    localparam int NCH = 3;
    localparam int DIV = 32;
    localparam int OUTPH = NCH + 1;
    localparam int LUT [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 181, 255};

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [3:0] wr_vol;
    logic [2:0] ch_on;
    logic [9:0] dac_code;
    logic       sample_valid;
    logic       pdm_out;

    ay_dac_mixer #(.CHANNELS(NCH), .SAMPLE_DIV(DIV), .LIN_W(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_vol(wr_vol),
        .ch_on(ch_on), .dac_code(dac_code), .sample_valid(sample_valid), .pdm_out(pdm_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mvol [NCH];
    int snap_sum = 0;
    int exp_dac = 0;
    int exp_valid = 0;
    int ph = 0;
    int last = -1;

    typedef struct {
        int v0; int v1; int v2;
        logic [2:0] on;
        int exp;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mix();
        int s = 0;
        for (int c = 0; c < NCH; c++) if (ch_on[c]) s += LUT[mvol[c]];
        return s;
    endfunction

    // One clock: advance the reference sample schedule, then compare outputs.
    task automatic step();
        int cur;
        @(posedge clk);
        if (rst) begin
            for (int c = 0; c < NCH; c++) mvol[c] = 0;
            exp_dac = 0; exp_valid = 0; ph = 0; last = -1;
        end else begin
            cur = ph;
            if (cur == 0) snap_sum = mix();
            if (wr_en && wr_ch < NCH) mvol[wr_ch] = int'(wr_vol);
            exp_valid = (cur == OUTPH) ? 1 : 0;
            if (cur == OUTPH) exp_dac = snap_sum;
            ph = (cur + 1) % DIV;
            last = cur;
        end
        #1;
        chk("dac_code", int'(dac_code), exp_dac);
        chk("sample_valid", int'(sample_valid), exp_valid);
`ifndef SIGMA_DELTA_EN
        chk("pdm_out_tied", int'(pdm_out), 0);
`endif
    endtask

    task automatic do_write(input int c, input int v);
        wr_en = 1'b1; wr_ch = 2'(c); wr_vol = 4'(v);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_out();
        do step(); while (last != 0);
        do step(); while (last != OUTPH);
    endtask

    task automatic finish_current();
        do step(); while (last != OUTPH);
    endtask

    task automatic run_to_phase(input int p);
        while (ph != p) step();
    endtask

    task automatic count_to_first_valid(input string name);
        int n = 0;
        do begin step(); n++; end while (!sample_valid && n < 3 * DIV);
        chk(name, n, OUTPH + 1);
        chk({name, "_dac"}, int'(dac_code), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        vecs[0] = '{15, 0, 0, 3'b001, 255};
        vecs[1] = '{15, 15, 15, 3'b111, 765};
        vecs[2] = '{15, 15, 15, 3'b000, 0};
        vecs[3] = '{13, 13, 0, 3'b011, 256};
        vecs[4] = '{5, 7, 9, 3'b101, 40};
        vecs[5] = '{1, 14, 3, 3'b110, 185};

        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_vol = '0; ch_on = '0;
        step(); step();
        chk("reset_dac", int'(dac_code), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_pdm", int'(pdm_out), 0);
        rst = 1'b0;
        count_to_first_valid("first_valid_edge");

        for (int i = 0; i < 6; i++) begin
            do_write(0, vecs[i].v0);
            do_write(1, vecs[i].v1);
            do_write(2, vecs[i].v2);
            ch_on = vecs[i].on;
            wait_out();
            chk($sformatf("vec%0d", i), int'(dac_code), vecs[i].exp);
        end

        cnt = 0;
        for (int i = 0; i < 2 * DIV; i++) begin step(); cnt += int'(sample_valid); end
        chk("valid_per_64", cnt, 2);

        ch_on = 3'b010;
        for (int v = 0; v < 16; v++) begin
            do_write(1, v);
            wait_out();
            chk($sformatf("sweep%0d", v), int'(dac_code), LUT[v]);
        end

        ch_on = 3'b111;
        do_write(0, 4); do_write(1, 4); do_write(2, 4);
        do_write(3, 9);
        wait_out();
        chk("wr_ch_out_of_range", int'(dac_code), 18);

        ch_on = 3'b001;
        do_write(0, 0);
        wait_out();
        run_to_phase(0);
        do_write(0, 15);
        finish_current();
        chk("phase0_write_old", int'(dac_code), 0);
        wait_out();
        chk("phase0_write_new", int'(dac_code), 255);

        do_write(0, 0);
        wait_out();
        run_to_phase(2);
        do_write(0, 15);
        finish_current();
        chk("phase2_write_old", int'(dac_code), 0);
        wait_out();
        chk("phase2_write_new", int'(dac_code), 255);

        run_to_phase(2);
        rst = 1'b1; step(); rst = 1'b0;
        count_to_first_valid("midsample_reset");

        for (int i = 0; i < 40 * DIV; i++) begin
            wr_en  = ($urandom_range(5) == 0);
            wr_ch  = 2'($urandom_range(3));
            wr_vol = 4'($urandom_range(15));
            if ($urandom_range(39) == 0) ch_on = 3'($urandom_range(7));
            step();
        end
        wr_en = 1'b0;

`ifdef SIGMA_DELTA_EN
        ch_on = 3'b011;
        do_write(0, 13); do_write(1, 13); do_write(2, 0);
        wait_out();
        chk("sd_dac", int'(dac_code), 256);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin step(); cnt += int'(pdm_out); end
        checks++;
        if (cnt < 255 || cnt > 257) begin
            errors++;
            $display("FAIL pdm_duty: got %0d highs expected 256+-1", cnt);
        end
        run_to_phase(10);
        rst = 1'b1; step();
        chk("sd_reset_pdm", int'(pdm_out), 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); chk("sd_after_reset", int'(pdm_out), 0); end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
